// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the two requesters / ALU and the shared-ALU arbiter.
// The master side is the environment (requesters plus the ALU output);
// the slave side is the arbiter itself.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [2:0]       op0;
  logic [2:0]       op1;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, alu_result, alu_zero,
    input  alu_a, alu_b, alu_op, gnt0, gnt1, done0, done1, result, zero, busy
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, alu_result, alu_zero,
    output alu_a, alu_b, alu_op, gnt0, gnt1, done0, done1, result, zero, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency ALU between two
// requesters. One operation at a time: accept, hold ALU inputs for LAT
// cycles, capture the result, pulse done for one cycle, return to idle.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT   = 3
) (
  input logic             clk,
  input logic             rst_n,
  alu_share_arbiter_if.slave bus
);

  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("alu_share_arbiter: LAT must be in 1..15");
  end

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             pick;

  // Round-robin choice: on a tie the requester that did not go last wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick = ~last_q;
    end else begin
      pick = bus.req1;
    end
  end

  // Next-state and registered-output computation for the three-phase sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win_d    = win_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win_d    = pick;
          alu_a_d  = pick ? bus.a1  : bus.a0;
          alu_b_d  = pick ? bus.b1  : bus.b0;
          alu_op_d = pick ? bus.op1 : bus.op0;
          gnt0_d   = ~pick;
          gnt1_d   = pick;
          cnt_d    = LAT_CNT;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d    = 4'd0;
          result_d = bus.alu_result;
          zero_d   = bus.alu_zero;
          gnt0_d   = 1'b0;
          gnt1_d   = 1'b0;
          done0_d  = ~win_q;
          done1_d  = win_q;
          last_d   = win_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 3'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;
  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = (state_q != IDLE);

endmodule
